iob_timer_alarm: RTL and testbench

//  Downstream consumer of the timer's free-running 2*DATA_W time count. Holds a
//  64-bit compare value; raises a sticky pending flag and an interrupt on match.

---
 rtl/iob_timer_alarm_pkg.sv | 24 ++
 rtl/iob_timer_alarm_core.sv | 77 +++++++
 rtl/iob_timer_alarm.sv | 92 +++++++++
 tb/tb_iob_timer_alarm.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_timer_alarm_pkg.sv
// Shared definitions for the timer alarm: register map, CTRL/STATUS bit
// positions and the alarm state encoding.
package iob_timer_alarm_pkg;

  localparam int ALARM_CMP_LO = 0;
  localparam int ALARM_CMP_HI = 1;
  localparam int ALARM_PER_LO = 2;
  localparam int ALARM_PER_HI = 3;
  localparam int ALARM_CTRL   = 4;
  localparam int ALARM_STATUS = 5;

  localparam int CTRL_ENABLE    = 0;
  localparam int CTRL_PERIODIC  = 1;
  localparam int CTRL_IRQ_EN    = 2;
  localparam int STATUS_PENDING = 0;
  localparam int STATUS_OVERRUN = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DONE  = 2'd2
  } alarm_state_e;

endpackage

// File: rtl/iob_timer_alarm_core.sv
// Alarm engine: arm/fire state machine, unsigned time >= compare check,
// periodic auto-reload of the compare value and sticky pending/overrun flags.
module iob_timer_alarm_core
  import iob_timer_alarm_pkg::*;
#(
  parameter int TIME_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              periodic,
  input  logic              cmp_load,
  input  logic [TIME_W-1:0] cmp_load_val,
  input  logic [TIME_W-1:0] period,
  input  logic [TIME_W-1:0] time_in,
  input  logic [1:0]        status_clr,
  output logic [TIME_W-1:0] cmp,
  output logic              pending,
  output logic              overrun
);

  alarm_state_e      state_q, state_d;
  logic [TIME_W-1:0] cmp_d;
  logic              pending_d, overrun_d;
  logic              fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cmp     <= '0;
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state_q <= state_d;
      cmp     <= cmp_d;
      pending <= pending_d;
      overrun <= overrun_d;
    end
  end

  // A compare commit in the same cycle replaces the value being matched, so
  // it suppresses any match against the old compare value.
  always_comb begin
    state_d = state_q;
    cmp_d   = cmp;
    fire    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (!cmp_load && (time_in >= cmp)) begin
          fire = 1'b1;
          if (periodic && (period != '0)) cmp_d = cmp + period;
          else                            state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!enable) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (cmp_load) begin
      cmp_d = cmp_load_val;
      if (enable) state_d = ST_ARMED;
    end
  end

  // A fire always wins over a software clear landing in the same cycle.
  always_comb begin
    pending_d = fire | (pending & ~status_clr[STATUS_PENDING]);
    overrun_d = (fire & pending) | (overrun & ~status_clr[STATUS_OVERRUN]);
  end

endmodule

// File: rtl/iob_timer_alarm.sv
// Timer alarm peripheral: native-bus register decode, compare low-half shadow,
// period and control registers around the alarm core.
module iob_timer_alarm
  import iob_timer_alarm_pkg::*;
#(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   rdata,
  output logic                ready,
  input  logic [2*DATA_W-1:0] time_in,
  output logic                irq
);

  localparam int TIME_W = 2 * DATA_W;

  logic [DATA_W-1:0] cmp_shadow;
  logic [TIME_W-1:0] period;
  logic [2:0]        ctrl;
  logic [TIME_W-1:0] cmp;
  logic              pending, overrun;
  logic              wr, rd, cmp_load;
  logic [1:0]        status_clr;
  logic [DATA_W-1:0] rd_val;

  assign wr         = valid & (|wstrb);
  assign rd         = valid & ~(|wstrb);
  assign cmp_load   = wr && (address == ADDR_W'(ALARM_CMP_HI));
  assign status_clr = (wr && (address == ADDR_W'(ALARM_STATUS))) ? wdata[1:0] : 2'b00;

  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_shadow <= '0;
      period     <= '0;
      ctrl       <= '0;
      ready      <= 1'b0;
      rdata      <= '0;
    end else begin
      ready <= valid;
      rdata <= rd ? rd_val : '0;
      if (wr) begin
        case (address)
          ADDR_W'(ALARM_CMP_LO): cmp_shadow              <= wdata;
          ADDR_W'(ALARM_PER_LO): period[DATA_W-1:0]      <= wdata;
          ADDR_W'(ALARM_PER_HI): period[TIME_W-1:DATA_W] <= wdata;
          ADDR_W'(ALARM_CTRL):   ctrl                    <= wdata[2:0];
          default: ;
        endcase
      end
    end
  end

  // CMP_LO reads the committed compare, never the pending shadow.
  always_comb begin
    rd_val = '0;
    case (address)
      ADDR_W'(ALARM_CMP_LO): rd_val = cmp[DATA_W-1:0];
      ADDR_W'(ALARM_CMP_HI): rd_val = cmp[TIME_W-1:DATA_W];
      ADDR_W'(ALARM_PER_LO): rd_val = period[DATA_W-1:0];
      ADDR_W'(ALARM_PER_HI): rd_val = period[TIME_W-1:DATA_W];
      ADDR_W'(ALARM_CTRL):   rd_val = DATA_W'(ctrl);
      ADDR_W'(ALARM_STATUS): rd_val = DATA_W'({overrun, pending});
      default:               rd_val = '0;
    endcase
  end

  iob_timer_alarm_core #(
    .TIME_W(TIME_W)
  ) u_core (
    .clk         (clk),
    .rst         (rst),
    .enable      (ctrl[CTRL_ENABLE]),
    .periodic    (ctrl[CTRL_PERIODIC]),
    .cmp_load    (cmp_load),
    .cmp_load_val({wdata, cmp_shadow}),
    .period      (period),
    .time_in     (time_in),
    .status_clr  (status_clr),
    .cmp         (cmp),
    .pending     (pending),
    .overrun     (overrun)
  );

  assign irq = pending & ctrl[CTRL_IRQ_EN];

endmodule

// File: tb/tb_iob_timer_alarm.sv
// Self-checking bench for iob_timer_alarm: bus reads are scoreboarded and
// irq is checked against the expected match threshold while time ramps.
module tb_iob_timer_alarm;

  logic        clk;
  logic        rst;
  logic        valid;
  logic [2:0]  address;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic        ready;
  logic [63:0] time_in;
  logic        irq;

  int tests_run = 0;
  int failures  = 0;

  typedef struct {
    bit          is_read;
    logic [31:0] exp;
    string       tag;
  } txn_t;

  txn_t sb[$];

  iob_timer_alarm #(.ADDR_W(3), .DATA_W(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .valid  (valid),
    .address(address),
    .wdata  (wdata),
    .wstrb  (wstrb),
    .rdata  (rdata),
    .ready  (ready),
    .time_in(time_in),
    .irq    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Response monitor: every ready pops one scoreboard entry; reads compare rdata.
  always @(posedge clk) begin : monitor
    txn_t t;
    #1;
    if (ready) begin
      if (sb.size() == 0) begin
        check_output("unexpected_ready", {63'd0, ready}, 64'd0);
      end else begin
        t = sb.pop_front();
        if (t.is_read) check_output(t.tag, {32'd0, rdata}, {32'd0, t.exp});
      end
    end
  end

  task automatic drive_req(input logic [2:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input string tag, input logic [31:0] exp);
    txn_t t;
    valid   = 1'b1;
    address = addr;
    wdata   = data;
    wstrb   = strb;
    t.is_read = (strb == 4'h0);
    t.exp     = exp;
    t.tag     = tag;
    sb.push_back(t);
  endtask

  task automatic end_req();
    @(negedge clk);
    valid = 1'b0;
    wstrb = 4'h0;
    for (int n = 0; n < 8 && sb.size() != 0; n++) @(negedge clk);
    if (sb.size() != 0) begin
      check_output("ready_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
    @(negedge clk);
    drive_req(addr, data, 4'hF, "write", 32'd0);
    end_req();
  endtask

  task automatic bus_read(input logic [2:0] addr, input logic [31:0] exp, input string tag);
    @(negedge clk);
    drive_req(addr, 32'd0, 4'h0, tag, exp);
    end_req();
  endtask

  task automatic set_time(input logic [63:0] t);
    @(negedge clk);
    time_in = t;
  endtask

  // Ramp time_in and expect irq exactly when time has reached thr.
  task automatic ramp_irq(input longint unsigned from, input longint unsigned to,
                          input logic [63:0] thr, input string tag);
    for (longint unsigned v = from; v <= to; v++) begin
      @(negedge clk);
      time_in = v;
      @(posedge clk);
      #1;
      check_output(tag, {63'd0, irq}, {63'd0, (v >= thr)});
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; valid = 1'b0; address = '0; wdata = '0; wstrb = '0; time_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_ready", {63'd0, ready}, 64'd0);
    check_output("rst_rdata", {32'd0, rdata}, 64'd0);
    check_output("rst_irq",   {63'd0, irq},   64'd0);
    @(negedge clk);
    rst = 1'b0;
    bus_read(3'd0, 32'd0, "rst_cmp_lo");
    bus_read(3'd4, 32'd0, "rst_ctrl");
    bus_read(3'd5, 32'd0, "rst_status");

    // One-shot at 100, no refire later
    bus_write(3'd0, 32'd100);
    bus_write(3'd1, 32'd0);
    bus_write(3'd4, 32'h5);
    ramp_irq(0, 120, 64'd100, "oneshot_irq");
    bus_read(3'd5, 32'h1, "oneshot_status");
    bus_write(3'd5, 32'h1);
    ramp_irq(121, 250, '1, "oneshot_norefire");
    bus_read(3'd5, 32'h0, "oneshot_status_clr");
    bus_write(3'd4, 32'h0);

    // Periodic 100/150/200 with overrun
    set_time(64'd0);
    bus_write(3'd2, 32'd50);
    bus_write(3'd3, 32'd0);
    bus_write(3'd0, 32'd100);
    bus_write(3'd1, 32'd0);
    bus_write(3'd4, 32'h7);
    ramp_irq(0, 120, 64'd100, "per_irq1");
    bus_read(3'd5, 32'h1, "per_status1");
    bus_read(3'd0, 32'd150, "per_cmp150");
    ramp_irq(121, 160, 64'd0, "per_irq2");
    bus_read(3'd5, 32'h3, "per_overrun");
    bus_read(3'd0, 32'd200, "per_cmp200");
    bus_write(3'd5, 32'h3);
    bus_read(3'd5, 32'h0, "per_w1c");
    ramp_irq(161, 205, 64'd200, "per_irq3");
    bus_read(3'd5, 32'h1, "per_status3");
    bus_read(3'd0, 32'd250, "per_cmp250");
    bus_write(3'd4, 32'h0);
    bus_write(3'd5, 32'h3);

    // Atomic compare update: shadow write alone must not fire
    bus_write(3'd0, 32'd0);
    bus_write(3'd1, 32'hFFFF_FFFF);
    set_time(64'd10);
    bus_write(3'd4, 32'h5);
    bus_write(3'd0, 32'd5);
    bus_read(3'd0, 32'd0, "atomic_cmp_lo_committed");
    bus_read(3'd5, 32'h0, "atomic_nofire_status");
    check_output("atomic_nofire_irq", {63'd0, irq}, 64'd0);
    bus_write(3'd1, 32'd0);
    @(posedge clk);
    #1;
    check_output("atomic_fire_irq", {63'd0, irq}, 64'd1);
    bus_read(3'd5, 32'h1, "atomic_status");
    bus_read(3'd1, 32'd0, "atomic_cmp_hi");
    bus_read(3'd0, 32'd5, "atomic_cmp_lo");
    bus_write(3'd4, 32'h0);
    bus_write(3'd5, 32'h3);

    // Fire and W1C in the same cycle: fire wins
    set_time(64'd50);
    bus_write(3'd2, 32'd1000);
    bus_write(3'd3, 32'd0);
    bus_write(3'd0, 32'd100);
    bus_write(3'd1, 32'd0);
    bus_write(3'd4, 32'h7);
    set_time(64'd100);
    @(posedge clk);
    #1;
    check_output("race_first_irq", {63'd0, irq}, 64'd1);
    bus_read(3'd5, 32'h1, "race_status_pre");
    @(negedge clk);
    time_in = 64'd1100;
    drive_req(3'd5, 32'h1, 4'hF, "race_w1c", 32'd0);
    end_req();
    bus_read(3'd5, 32'h3, "race_status_post");
    bus_read(3'd0, 32'd2100, "race_cmp");
    bus_write(3'd4, 32'h0);
    bus_write(3'd5, 32'h3);

    // Periodic wrap past 2^64
    set_time(64'hFFFF_FFFF_FFFF_FFE0);
    bus_write(3'd2, 32'h20);
    bus_write(3'd3, 32'd0);
    bus_write(3'd0, 32'hFFFF_FFF0);
    bus_write(3'd1, 32'hFFFF_FFFF);
    bus_write(3'd4, 32'h7);
    repeat (2) @(negedge clk);
    time_in = 64'hFFFF_FFFF_FFFF_FFF0;
    @(negedge clk);
    time_in = 64'd0;
    @(posedge clk);
    #1;
    check_output("wrap_irq", {63'd0, irq}, 64'd1);
    bus_read(3'd0, 32'h10, "wrap_cmp_lo");
    bus_read(3'd1, 32'h0, "wrap_cmp_hi");
    bus_read(3'd5, 32'h1, "wrap_status");
    bus_write(3'd5, 32'h1);
    ramp_irq(0, 20, 64'h10, "wrap_refire");
    bus_read(3'd0, 32'h30, "wrap_cmp_next");

    // Reset while armed with pending set
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_output("midrst_irq",   {63'd0, irq},   64'd0);
    check_output("midrst_ready", {63'd0, ready}, 64'd0);
    check_output("midrst_rdata", {32'd0, rdata}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    bus_read(3'd4, 32'h0, "midrst_ctrl");
    bus_read(3'd5, 32'h0, "midrst_status");
    bus_read(3'd2, 32'h0, "midrst_per_lo");
    bus_read(3'd0, 32'h0, "midrst_cmp_lo");
    bus_write(3'd1, 32'h0);
    bus_read(3'd0, 32'h0, "midrst_shadow");

    // Unmapped addresses and partial strobes
    bus_write(3'd6, 32'hDEAD_BEEF);
    bus_read(3'd6, 32'h0, "unmapped6");
    bus_read(3'd7, 32'h0, "unmapped7");
    @(negedge clk);
    drive_req(3'd3, 32'h1234_5678, 4'b0001, "partial_wr", 32'd0);
    end_req();
    bus_read(3'd3, 32'h1234_5678, "partial_per_hi");

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
